// File: rtl/mem_stage_pkg.sv
// Shared types and funct3 encodings for the memory access stage.
// Pure declarations; no logic, no latency.
package mem_stage_pkg;

  typedef enum logic {IDLE, WAIT} mem_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

endpackage

// File: rtl/load_store_align.sv
// Byte-lane steering for stores, lane extraction/extension for loads, misalignment flag.
// Purely combinational: zero latency, no flow control.
module load_store_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
  assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  // Access size comes from funct3[1:0] for both loads and stores.
  always_comb begin
    be    = 4'b1111;
    wdata = store_data;
    case (funct3[1:0])
      2'b00: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        be    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    load_data = rdata;
    case (funct3)
      F3_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  load_data = {24'h0, byte_sel};
      F3_LHU:  load_data = {16'h0, half_sel};
      default: load_data = rdata;
    endcase
  end

  assign misaligned = ((funct3 == F3_LW) && (addr_lo != 2'b00)) ||
                      (((funct3 == F3_LH) || (funct3 == F3_LHU)) && addr_lo[0]);

endmodule

// File: rtl/memory_access_stage.sv
// RV32I MEM stage: data-memory req/ready access, branch resolve, MEM/WB register (1-cycle latency).
// Stalls upstream while an access waits on dmem_ready_i; MEM_TIMEOUT_EN adds a wait-cycle abort.
module memory_access_stage
  import mem_stage_pkg::*;
#(
  parameter int DMEM_AW        = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               MemtoReg_MEMORYACCESS,
  input  logic               MemWrite_MEMORYACCESS,
  input  logic               MemRead_MEMORYACCESS,
  input  logic               RegWrite_MEMORYACCESS,
  input  logic               Branch_MEMORYACCESS,
  input  logic               zero_MEMORYACCESS,
  input  logic [31:0]        PCTarget_MEMORYACCESS,
  input  logic [31:0]        ALUResult_MEMORYACCESS,
  input  logic [31:0]        ReadData2_MEMORYACCESS,
  input  logic [4:0]         Write_Register_MEMORYACCESS,
  input  logic [2:0]         funct3_MEMORYACCESS,
  output logic               dmem_req_o,
  output logic               dmem_we_o,
  output logic [DMEM_AW-1:0] dmem_addr_o,
  output logic [3:0]         dmem_be_o,
  output logic [31:0]        dmem_wdata_o,
  input  logic [31:0]        dmem_rdata_i,
  input  logic               dmem_ready_i,
  output logic               stall_o,
  output logic               PCSrc_o,
  output logic [31:0]        PCTarget_o,
  output logic               misalign_o,
  output logic               bus_err_o,
  output logic [31:0]        ReadData_WRITEBACK,
  output logic [31:0]        ALUResult_WRITEBACK,
  output logic [4:0]         Write_Register_WRITEBACK,
  output logic               RegWrite_WRITEBACK,
  output logic               MemtoReg_WRITEBACK
);

  if (TIMEOUT_CYCLES < 1 || DMEM_AW < 2 || DMEM_AW > 32) begin : g_param_check
    $error("memory_access_stage: parameter out of range");
  end

  mem_state_t  state, state_nxt;
  logic        mem_op, misaligned, misalign_hit, access;
  logic        timeout_hit, bubble;
  logic [31:0] load_data;

  load_store_align u_align (
    .funct3     (funct3_MEMORYACCESS),
    .addr_lo    (ALUResult_MEMORYACCESS[1:0]),
    .store_data (ReadData2_MEMORYACCESS),
    .rdata      (dmem_rdata_i),
    .be         (dmem_be_o),
    .wdata      (dmem_wdata_o),
    .load_data  (load_data),
    .misaligned (misaligned)
  );

  assign mem_op       = MemRead_MEMORYACCESS | MemWrite_MEMORYACCESS;
  assign misalign_hit = mem_op & misaligned & ~reset_i;
  assign access       = mem_op & ~misaligned;

  assign dmem_we_o   = MemWrite_MEMORYACCESS;
  assign dmem_addr_o = ALUResult_MEMORYACCESS[DMEM_AW-1:0];
  assign PCSrc_o     = ~reset_i & Branch_MEMORYACCESS & zero_MEMORYACCESS;
  assign PCTarget_o  = PCTarget_MEMORYACCESS;

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;
`endif

  always_comb begin
    state_nxt   = state;
    dmem_req_o  = 1'b0;
    stall_o     = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          dmem_req_o = 1'b1;
          if (!dmem_ready_i) begin
            stall_o   = 1'b1;
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        dmem_req_o = 1'b1;
        if (dmem_ready_i) begin
          state_nxt = IDLE;
        end else begin
          stall_o = 1'b1;
`ifdef MEM_TIMEOUT_EN
          if (wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            stall_o     = 1'b0;
            timeout_hit = 1'b1;
            state_nxt   = IDLE;
          end
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Reset abandons any outstanding access in the same cycle.
    if (reset_i) begin
      dmem_req_o  = 1'b0;
      stall_o     = 1'b0;
      timeout_hit = 1'b0;
      state_nxt   = IDLE;
    end
  end

  assign bubble = stall_o | misalign_hit | timeout_hit;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state      <= IDLE;
      misalign_o <= 1'b0;
    end else begin
      state      <= state_nxt;
      misalign_o <= misalign_hit;
    end
  end

`ifdef MEM_TIMEOUT_EN
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wait_cnt  <= '0;
      bus_err_o <= 1'b0;
    end else begin
      wait_cnt  <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
      bus_err_o <= timeout_hit;
    end
  end
`else
  assign bus_err_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i || bubble) begin
      ReadData_WRITEBACK       <= '0;
      ALUResult_WRITEBACK      <= '0;
      Write_Register_WRITEBACK <= '0;
      RegWrite_WRITEBACK       <= 1'b0;
      MemtoReg_WRITEBACK       <= 1'b0;
    end else begin
      ReadData_WRITEBACK       <= MemRead_MEMORYACCESS ? load_data : 32'h0;
      ALUResult_WRITEBACK      <= ALUResult_MEMORYACCESS;
      Write_Register_WRITEBACK <= Write_Register_MEMORYACCESS;
      RegWrite_WRITEBACK       <= RegWrite_MEMORYACCESS & ~MemWrite_MEMORYACCESS;
      MemtoReg_WRITEBACK       <= MemtoReg_MEMORYACCESS;
    end
  end

endmodule

// File: doc/memory_access_stage.md
Name: memory_access_stage

Overview:
- MEM stage of the 5-stage RV32I pipeline. Consumes the EX/MEM register outputs, performs loads and stores on the data memory through a req/ready handshake, and resolves branches.
- Holds the MEM/WB pipeline register.
- Stalls the front of the pipeline while a memory access is outstanding.
- Handles byte/half/word lane steering, sign/zero extension and misalignment detection.

Parameters:
- DMEM_AW, 32, data-memory byte-address width driven on dmem_addr_o (low DMEM_AW bits of ALUResult).
- TIMEOUT_CYCLES, 16, wait-cycle limit before abort; used only with MEM_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous active-high reset.
- MemtoReg_MEMORYACCESS  in  1  writeback selects load data.
- MemWrite_MEMORYACCESS  in  1  store.
- MemRead_MEMORYACCESS  in  1  load.
- RegWrite_MEMORYACCESS  in  1  destination write enable.
- Branch_MEMORYACCESS  in  1  branch instruction.
- zero_MEMORYACCESS  in  1  ALU zero flag.
- PCTarget_MEMORYACCESS  in  32  branch target.
- ALUResult_MEMORYACCESS  in  32  effective address or ALU result.
- ReadData2_MEMORYACCESS  in  32  store data.
- Write_Register_MEMORYACCESS  in  5  rd.
- funct3_MEMORYACCESS  in  3  access size/sign.
- dmem_req_o  out  1  access request.
- dmem_we_o  out  1  write request.
- dmem_addr_o  out  DMEM_AW  byte address.
- dmem_be_o  out  4  byte enables.
- dmem_wdata_o  out  32  lane-steered store data.
- dmem_rdata_i  in  32  raw read word.
- dmem_ready_i  in  1  access complete this cycle.
- stall_o  out  1  hold PC, IF/ID, ID/EX, EX/MEM.
- PCSrc_o  out  1  take branch.
- PCTarget_o  out  32  branch target passthrough.
- misalign_o  out  1  one-cycle pulse, misaligned access suppressed.
- bus_err_o  out  1  one-cycle pulse, access timed out.
- ReadData_WRITEBACK  out  32  extended load data.
- ALUResult_WRITEBACK  out  32  ALU result.
- Write_Register_WRITEBACK  out  5  rd.
- RegWrite_WRITEBACK  out  1  write enable.
- MemtoReg_WRITEBACK  out  1  select load data.

Behaviour:
- Clock and reset: one clock clk_i; reset_i is synchronous active-high. On reset, state = IDLE and every registered output (all *_WRITEBACK, misalign_o, bus_err_o, timeout counter) is cleared to 0. While reset_i=1, dmem_req_o, stall_o and PCSrc_o are forced to 0.
- Memory operation: mem_op = MemRead|MemWrite.
- Alignment and misalignment:
  - funct3 010 (word) requires addr[1:0]=00.
  - funct3 001/101 (half) requires addr[0]=0.
  - A misaligned access issues no request, does not stall, pulses misalign_o the next cycle, and writes a bubble into MEM/WB (RegWrite=0).
- State IDLE:
  - If mem_op and aligned: dmem_req_o=1 combinationally.
  - If dmem_ready_i=1 in the same cycle, the access completes with zero wait: stall_o=0, MEM/WB captures.
  - Otherwise go to WAIT and assert stall_o=1 in this cycle.
- State WAIT:
  - dmem_req_o=1 and stall_o=1.
  - Address, we, be and wdata stay stable; upstream registers hold their contents.
  - On dmem_ready_i=1: stall_o=0, MEM/WB captures the load, state returns to IDLE.
- Pipeline register while stalled: MEM/WB captures a bubble (RegWrite=0, MemtoReg=0, other fields 0) on every stalled cycle.
- Non-memory instructions: MEM/WB captures ALUResult, rd, RegWrite and MemtoReg every cycle; latency is 1 cycle.
- Stores:
  - SB: be = 0001 << addr[1:0]; wdata = byte replicated x4.
  - SH: be = 0011 or 1100 by addr[1]; wdata = half replicated x2.
  - SW: be = 1111.
  - dmem_we_o = MemWrite.
  - Stores never set RegWrite_WRITEBACK.
- Loads: select the lane by addr[1:0].
  - LB/LH sign-extend.
  - LBU/LHU zero-extend.
  - LW passes the word through.
  - Undefined funct3 values treated as LW.
- Branch resolution: PCSrc_o = Branch & zero, combinational, independent of the FSM. Branches never carry mem_op.
- Reset mid-access: reset in WAIT returns to IDLE; the outstanding access is abandoned and dmem_req_o drops in the reset cycle.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined: a counter increments in WAIT. If it reaches TIMEOUT_CYCLES without dmem_ready_i, the FSM returns to IDLE, releases the stall, writes a bubble into MEM/WB and pulses bus_err_o for one cycle. The counter clears on entry to WAIT.
- Undefined: WAIT lasts indefinitely, there is no counter, and bus_err_o is tied to 0.

Decomposition:
- Shared package mem_stage_pkg:
  - typedef enum logic {IDLE, WAIT} mem_state_t;
  - funct3 constants F3_LB=000, F3_LH=001, F3_LW=010, F3_LBU=100, F3_LHU=101, F3_SB=000, F3_SH=001, F3_SW=010.
- One sub-module: load_store_align, purely combinational. Computes store be/wdata, load extraction/extension, and the misalign flag.

Test Plan:
- SW addr 0x100, data 0xDEADBEEF, ready same cycle -> req=1, we=1, be=1111, stall_o never 1, RegWrite_WRITEBACK=0 next cycle.
- LB addr 0x103, rdata 0x80FF_FF7F, ready after 3 cycles -> stall_o high for exactly 3 cycles, then ReadData_WRITEBACK=0xFFFFFF80, MemtoReg_WRITEBACK=1.
- LHU addr 0x202, rdata 0xABCD_1234 -> ReadData_WRITEBACK=0x0000ABCD. SH addr 0x202, data 0x5678 -> be=1100, wdata=0x56785678.
- LW addr 0x101 -> no req, misalign_o=1 next cycle, RegWrite_WRITEBACK=0, no stall.
- Branch=1, zero=1, PCTarget=0x40 -> PCSrc_o=1, PCTarget_o=0x40 same cycle. With zero=0 -> PCSrc_o=0.
- LW stalled in WAIT, reset_i asserted for 1 cycle -> req drops, state IDLE, all WB outputs 0. With MEM_TIMEOUT_EN and ready never asserted -> bus_err_o pulses after 16 wait cycles and the stall releases.
